// File: rtl/jamma_input_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : jamma_input_scanner
//  Purpose  : Conditions multiplexed JAMMA player inputs, coin, service and
//             test switches before they reach the arcade core. Drives the
//             splitter select line, samples each player bank after a settle
//             window, debounces buttons, merges the keyboard joystick into
//             player 1 and stretches coin insertions into single-shot pulses.
//  Revision : 1.0  initial release
// ============================================================================
module jamma_input_scanner #(
    parameter int SETTLE_CYC  = 16,
    parameter int DEB_SAMPLES = 4,
    parameter int COIN_HOLD   = 200000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] JJOY,
    input  logic [1:0] JCOIN,
    input  logic       JSERVICE,
    input  logic       JTEST,
    input  logic [5:0] KBD_JOY,
    output logic       JSELECT,
    output logic [7:0] JOY1,
    output logic [7:0] JOY2,
    output logic [1:0] COIN,
    output logic       SERVICE,
    output logic       TEST,
    output logic       SCAN_STB
);

    // Counter widths sized so the terminal value always fits (no wrap).
    localparam int c_SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int c_DBW = $clog2(DEB_SAMPLES + 1);
    localparam int c_CCW = (COIN_HOLD > 1) ? $clog2(COIN_HOLD) : 1;

    localparam logic [c_SCW-1:0] c_SET_LAST  = c_SCW'(SETTLE_CYC - 1);
    localparam logic [c_DBW-1:0] c_DEB_LAST  = c_DBW'(DEB_SAMPLES - 1);
    localparam logic [c_CCW-1:0] c_COIN_LAST = c_CCW'(COIN_HOLD - 1);

    typedef enum logic [1:0] {
        S0_SETTLE = 2'd0,
        S0_SAMPLE = 2'd1,
        S1_SETTLE = 2'd2,
        S1_SAMPLE = 2'd3
    } scan_state_t;

    typedef enum logic [1:0] {
        C_IDLE     = 2'd0,
        C_HOLD     = 2'd1,
        C_WAIT_REL = 2'd2
    } coin_state_t;

    // ------------------------------------------------------------------
    // Scan sequencer
    // ------------------------------------------------------------------
    scan_state_t      r_scan_state;
    scan_state_t      w_scan_next;
    logic [c_SCW-1:0] r_set_cnt;
    logic             w_set_last;
    logic             w_in_settle;
    logic             r_jselect;
    logic             r_scan_stb;

    assign w_set_last  = (r_set_cnt == c_SET_LAST);
    assign w_in_settle = (r_scan_state == S0_SETTLE) || (r_scan_state == S1_SETTLE);

    // Next-state decode for the P1/P2 scan cycle.
    always_comb begin
        w_scan_next = r_scan_state;
        case (r_scan_state)
            S0_SETTLE: if (w_set_last) w_scan_next = S0_SAMPLE;
            S0_SAMPLE: w_scan_next = S1_SETTLE;
            S1_SETTLE: if (w_set_last) w_scan_next = S1_SAMPLE;
            S1_SAMPLE: w_scan_next = S0_SETTLE;
            default:   w_scan_next = S0_SETTLE;
        endcase
    end

    // Scan state, settle counter, registered select and end-of-scan strobe.
    // JSELECT is registered from the next state so it only moves on entry
    // to a settle state and never glitches on state decode.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_scan_state <= S0_SETTLE;
            r_set_cnt    <= '0;
            r_jselect    <= 1'b0;
            r_scan_stb   <= 1'b0;
        end else begin
            r_scan_state <= w_scan_next;
            r_set_cnt    <= (w_in_settle && !w_set_last) ? r_set_cnt + 1'b1 : '0;
            r_jselect    <= (w_scan_next == S1_SETTLE) || (w_scan_next == S1_SAMPLE);
            r_scan_stb   <= (r_scan_state == S1_SAMPLE);
        end
    end

    assign JSELECT  = r_jselect;
    assign SCAN_STB = r_scan_stb;

    // ------------------------------------------------------------------
    // Per-bit debounce for both player banks
    // ------------------------------------------------------------------
    logic [7:0]       r_deb1;
    logic [7:0]       r_deb2;
    logic [c_DBW-1:0] r_dcnt1 [0:7];
    logic [c_DBW-1:0] r_dcnt2 [0:7];
    logic             w_p1_smp;
    logic             w_p2_smp;

    // JJOY is used directly here: the settle window already gives it
    // many clocks to resolve before it is looked at.
    assign w_p1_smp = (r_scan_state == S0_SAMPLE);
    assign w_p2_smp = (r_scan_state == S1_SAMPLE);

    // Debounce update, evaluated only on the owning player's sample slot.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_deb1 <= 8'hFF;
            r_deb2 <= 8'hFF;
            for (int i = 0; i < 8; i++) begin
                r_dcnt1[i] <= '0;
                r_dcnt2[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (w_p1_smp) begin
                    if (JJOY[i] == r_deb1[i]) begin
                        r_dcnt1[i] <= '0;
                    end else if (r_dcnt1[i] == c_DEB_LAST) begin
                        r_deb1[i]  <= JJOY[i];
                        r_dcnt1[i] <= '0;
                    end else begin
                        r_dcnt1[i] <= r_dcnt1[i] + 1'b1;
                    end
                end
                if (w_p2_smp) begin
                    if (JJOY[i] == r_deb2[i]) begin
                        r_dcnt2[i] <= '0;
                    end else if (r_dcnt2[i] == c_DEB_LAST) begin
                        r_deb2[i]  <= JJOY[i];
                        r_dcnt2[i] <= '0;
                    end else begin
                        r_dcnt2[i] <= r_dcnt2[i] + 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Player outputs (keyboard merged into P1 every clock)
    // ------------------------------------------------------------------
    logic [7:0] r_joy1;
    logic [7:0] r_joy2;

    // Output registers; keyboard path bypasses scan timing.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_joy1 <= 8'hFF;
            r_joy2 <= 8'hFF;
        end else begin
            r_joy1 <= r_deb1 & {2'b11, KBD_JOY};
            r_joy2 <= r_deb2;
        end
    end

    assign JOY1 = r_joy1;
    assign JOY2 = r_joy2;

    // ------------------------------------------------------------------
    // Service / test synchronizers
    // ------------------------------------------------------------------
    logic [1:0] r_st_s1;
    logic [1:0] r_st_s2;

    // Two-stage synchronizer for {JSERVICE, JTEST}.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_st_s1 <= 2'b11;
            r_st_s2 <= 2'b11;
        end else begin
            r_st_s1 <= {JSERVICE, JTEST};
            r_st_s2 <= r_st_s1;
        end
    end

    assign SERVICE = r_st_s2[1];
    assign TEST    = r_st_s2[0];

    // ------------------------------------------------------------------
    // Coin channels: synchronizer + single-shot pulse stretcher each
    // ------------------------------------------------------------------
    for (genvar g = 0; g < 2; g++) begin : g_coin
        logic             r_s1;
        logic             r_s2;
        coin_state_t      r_state;
        coin_state_t      w_next;
        logic [c_CCW-1:0] r_cnt;
        logic [c_CCW-1:0] w_cnt_next;
        logic             r_out;
        logic             w_out_next;

        // Two-stage synchronizer for the asynchronous coin switch.
        always_ff @(posedge CLK) begin
            if (RESET) begin
                r_s1 <= 1'b1;
                r_s2 <= 1'b1;
            end else begin
                r_s1 <= JCOIN[g];
                r_s2 <= r_s1;
            end
        end

        // Pulse FSM next-state: fixed-length low pulse, then wait for release.
        always_comb begin
            w_next     = r_state;
            w_cnt_next = r_cnt;
            w_out_next = r_out;
            case (r_state)
                C_IDLE: begin
                    if (!r_s2) begin
                        w_next     = C_HOLD;
                        w_cnt_next = c_COIN_LAST;
                        w_out_next = 1'b0;
                    end
                end
                C_HOLD: begin
                    if (r_cnt == '0) begin
                        w_next     = C_WAIT_REL;
                        w_out_next = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt - 1'b1;
                    end
                end
                C_WAIT_REL: begin
                    if (r_s2) w_next = C_IDLE;
                end
                default: begin
                    w_next     = C_IDLE;
                    w_cnt_next = '0;
                    w_out_next = 1'b1;
                end
            endcase
        end

        // Pulse FSM registers; reset aborts any pulse in progress.
        always_ff @(posedge CLK) begin
            if (RESET) begin
                r_state <= C_IDLE;
                r_cnt   <= '0;
                r_out   <= 1'b1;
            end else begin
                r_state <= w_next;
                r_cnt   <= w_cnt_next;
                r_out   <= w_out_next;
            end
        end

        assign COIN[g] = r_out;
    end

endmodule
`default_nettype wire
